// File: rtl/data_mem_sequencer_pkg.sv
// Shared types and constants for the data-memory sequencer and its load aligner.
package data_mem_sequencer_pkg;

  // Load/store size encodings as decoded by the control unit.
  typedef enum logic [1:0] {
    LS_WORD    = 2'b00,
    LS_HALF    = 2'b01,
    LS_BYTE    = 2'b10,
    LS_ILLEGAL = 2'b11
  } load_size_e;

  // Sequencer states: IDLE -> BEAT0 -> (BEAT1) -> FIN -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_FIN
  } state_e;

  // Byte-lane masks for an access placed at lane 0.
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Lane mask for a size; an illegal size enables no lanes.
  function automatic logic [3:0] size_mask(input load_size_e size);
    case (size)
      LS_WORD: return MASK_WORD;
      LS_HALF: return MASK_HALF;
      LS_BYTE: return MASK_BYTE;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_sequencer_if.sv
// Word-addressed req/ack data-memory bus with byte enables.
interface data_mem_sequencer_if #(
  parameter int AW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  // The sequencer issues beats; the memory acknowledges them.
  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_sequencer_load_align_ext.sv
// Combines up to two bus words into the byte stream starting at the access
// address, then sign- or zero-extends the byte/half result.
module load_align_ext
  import data_mem_sequencer_pkg::*;
(
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  input  logic [1:0]  i_offset,
  input  load_size_e  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_rdata
);

  logic [31:0] w_bytes;

  // Shift the two-word window down to the addressed byte and extend.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_rdata = '0;
    w_bytes = 32'({i_word1, i_word0} >> {i_offset, 3'b000});
    case (i_size)
      LS_WORD: o_rdata = w_bytes;
      LS_HALF: o_rdata = {{16{w_bytes[15] & ~i_unsigned}}, w_bytes[15:0]};
      LS_BYTE: o_rdata = {{24{w_bytes[7] & ~i_unsigned}}, w_bytes[7:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sequencer.sv
// Multi-cycle data-memory access controller: issues one or two bus beats per
// load/store, stalls the core meanwhile and reports completion or timeout.
module data_mem_sequencer
  import data_mem_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_is_store,
  input  logic [1:0]    i_load_size,
  input  logic          i_load_unsigned,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic          o_stall,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  data_mem_sequencer_if.master bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        r_state;
  logic          r_is_store;
  logic          r_unsigned;
  load_size_e    r_size;
  logic [1:0]    r_offset;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wdata_hi;
  logic [31:0]   r_word0;
  logic [CW-1:0] r_cnt;
  logic          r_stall;
  logic          r_done;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_bus_wdata;

  load_size_e    w_size;
  logic [7:0]    w_be_wide;
  logic [63:0]   w_wdata_wide;
  logic          w_timeout;
  logic [31:0]   w_word0;
  logic [31:0]   w_load_data;

  // Place the request on byte lanes; bits above lane 3 belong to the second beat.
  always_comb begin
    w_size       = load_size_e'(i_load_size);
    w_be_wide    = {4'b0000, size_mask(w_size)} << i_addr[1:0];
    w_wdata_wide = {32'h0, i_wdata} << {i_addr[1:0], 3'b000};
  end

  // The beat counter expires after TIMEOUT unacknowledged cycles; 0 disables it.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  // A single-beat load takes its word straight from the bus in the ack cycle.
  assign w_word0 = (r_state == ST_BEAT0) ? bus.bus_rdata : r_word0;

  load_align_ext u_load_align_ext (
    .i_word0    (w_word0),
    .i_word1    (bus.bus_rdata),
    .i_offset   (r_offset),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_rdata    (w_load_data)
  );

  // Access FSM with registered core and bus outputs.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= LS_WORD;
      r_offset    <= 2'b00;
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= '0;
      r_word0     <= '0;
      r_cnt       <= '0;
      r_stall     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_is_store <= i_is_store;
            r_unsigned <= i_load_unsigned;
            r_size     <= w_size;
            r_offset   <= i_addr[1:0];
            r_be_hi    <= w_be_wide[7:4];
            r_wdata_hi <= w_wdata_wide[63:32];
            r_cnt      <= '0;
            if (w_size == LS_ILLEGAL) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ST_BEAT0;
              r_stall     <= 1'b1;
              r_err       <= 1'b0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= i_is_store;
              r_bus_addr  <= {i_addr[AW-1:2], 2'b00};
              r_bus_be    <= w_be_wide[3:0];
              r_bus_wdata <= w_wdata_wide[31:0];
            end
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (bus.bus_ack) begin
            if ((r_state == ST_BEAT0) && (r_be_hi != 4'b0000)) begin
              r_state     <= ST_BEAT1;
              r_word0     <= bus.bus_rdata;
              r_cnt       <= '0;
              r_bus_addr  <= r_bus_addr + AW'(4);
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wdata_hi;
            end else begin
              r_state   <= ST_FIN;
              r_done    <= 1'b1;
              r_stall   <= 1'b0;
              r_bus_req <= 1'b0;
              r_bus_we  <= 1'b0;
              if (!r_is_store) r_rdata <= w_load_data;
            end
          end else if (w_timeout) begin
            r_state   <= ST_FIN;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_stall   <= 1'b0;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall       = r_stall;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_rdata       = r_rdata;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer: a vector table of single accesses
// against a scripted memory slave, plus hand-written multi-cycle sequences.
module tb_data_mem_sequencer;

  localparam int TIMEOUT = 16;
  localparam int AW      = 32;
  localparam logic [31:0] IDLE_RDATA = 32'hA5A5_A5A5;

  logic        CLK;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [1:0]  lsize;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_sequencer_if #(.AW(AW)) bus_if ();

  data_mem_sequencer #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .CLK             (CLK),
    .rst             (rst),
    .i_start         (start),
    .i_is_store      (is_store),
    .i_load_size     (lsize),
    .i_load_unsigned (uns),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .o_stall         (stall),
    .o_done          (done),
    .o_err           (err),
    .o_rdata         (rdata),
    .bus             (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // wait cycles before ack on each beat
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        split;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_done;  // cycle of done, counting the start cycle as 1
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; is_store = 1'b0; lsize = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0;
  endtask

  task automatic drive_start(input logic st, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; is_store = st; lsize = sz; uns = u; addr = a; wdata = wd;
  endtask

  // One access: pulse start, answer beats after v.delay waits, check bus and result.
  task automatic run_vec(input int idx, input vec_t v);
    int          wait_cnt;
    int          beat;
    int          req_cycles;
    int          done_cyc;
    int          exp_req;
    bit          got_done;
    logic [31:0] m;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    drive_start(v.is_store, v.size, v.uns, v.addr, v.wdata);
    @(negedge CLK);
    idle_inputs();
    wait_cnt = 0; beat = 0; req_cycles = 0; done_cyc = -1; got_done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
        break;
      end
      if (c == 0) check({tag, " stall rises"}, 32'(stall), 32'd1);
      if (bus_if.bus_req) begin
        req_cycles++;
        if (wait_cnt == 0 && beat < 2) begin
          m = lane_mask(beat == 0 ? v.be0 : v.be1);
          check($sformatf("%s beat%0d addr", tag, beat), bus_if.bus_addr, beat == 0 ? v.addr0 : v.addr1);
          check($sformatf("%s beat%0d be", tag, beat), 32'(bus_if.bus_be), 32'(beat == 0 ? v.be0 : v.be1));
          check($sformatf("%s beat%0d we", tag, beat), 32'(bus_if.bus_we), 32'(v.is_store));
          if (v.is_store)
            check($sformatf("%s beat%0d wdata", tag, beat), bus_if.bus_wdata & m, (beat == 0 ? v.wd0 : v.wd1) & m);
        end
        if (wait_cnt == v.delay) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = (beat == 0) ? v.rd0 : v.rd1;
          beat++;
          wait_cnt = 0;
        end else begin
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = IDLE_RDATA;
          wait_cnt++;
        end
      end else begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = IDLE_RDATA;
      end
      @(negedge CLK);
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = IDLE_RDATA;
    exp_req = v.exp_err ? TIMEOUT : (v.delay + 1) * (v.split ? 2 : 1);
    check({tag, " done seen"}, 32'(got_done), 32'd1);
    check({tag, " done cycle"}, done_cyc + 2, v.exp_done);
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
    check({tag, " rdata"}, rdata, v.exp_rdata);
    check({tag, " stall at done"}, 32'(stall), 32'd0);
    check({tag, " req at done"}, 32'(bus_if.bus_req), 32'd0);
    check({tag, " req cycles"}, req_cycles, exp_req);
    @(negedge CLK);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // is_store size uns addr wdata delay rd0 rd1 split addr0 be0 wd0 addr1 be1 wd1 exp_rdata exp_err exp_done
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        0,  32'hDEADBEEF, 32'h0,        1'b0, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h103, 32'h0,        0,  32'h80123456, 32'h0,        1'b0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[2]  = '{1'b0, 2'b10, 1'b1, 32'h103, 32'h0,        0,  32'h80123456, 32'h0,        1'b0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h00000080, 1'b0, 3};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h203, 32'h0000ABCD, 0,  32'h0,        32'h0,        1'b1, 32'h200, 4'b1000, 32'hCD000000, 32'h204, 4'b0001, 32'h000000AB, 32'h00000080, 1'b0, 4};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h002, 32'h0,        0,  32'h33445A5A, 32'h77661122, 1'b1, 32'h000, 4'b1100, 32'h0,        32'h004, 4'b0011, 32'h0,        32'h11223344, 1'b0, 4};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0FE, 32'h0,        0,  32'h80011234, 32'h0,        1'b0, 32'h0FC, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 3};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0FE, 32'h0,        1,  32'h80011234, 32'h0,        1'b0, 32'h0FC, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h00008001, 1'b0, 4};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h011, 32'h0,        0,  32'h12FEDC34, 32'h0,        1'b0, 32'h010, 4'b0110, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFFFEDC, 1'b0, 3};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h013, 32'h0,        0,  32'h7F000000, 32'hAAAAAA01, 1'b1, 32'h010, 4'b1000, 32'h0,        32'h014, 4'b0001, 32'h0,        32'h0000017F, 1'b0, 4};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h301, 32'h11223344, 2,  32'h0,        32'h0,        1'b1, 32'h300, 4'b1110, 32'h22334400, 32'h304, 4'b0001, 32'h00000011, 32'h0000017F, 1'b0, 8};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h402, 32'hFFFFFF5A, 1,  32'h0,        32'h0,        1'b0, 32'h400, 4'b0100, 32'h005A0000, 32'h0,   4'b0000, 32'h0,        32'h0000017F, 1'b0, 4};
    vecs[11] = '{1'b0, 2'b10, 1'b1, 32'h401, 32'h0,        15, 32'h0000C300, 32'h0,        1'b0, 32'h400, 4'b0010, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h000000C3, 1'b0, 18};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h003, 32'h0,        0,  32'h44000000, 32'hFF112233, 1'b1, 32'h000, 4'b1000, 32'h0,        32'h004, 4'b0111, 32'h0,        32'h11223344, 1'b0, 4};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 32'h500, 32'h0,        16, 32'h0,        32'h0,        1'b0, 32'h500, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h11223344, 1'b1, 18};

    idle_inputs();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = IDLE_RDATA;
    rst = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset values.
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset req", 32'(bus_if.bus_req), 32'd0);
    check("reset we", 32'(bus_if.bus_we), 32'd0);
    check("reset addr", bus_if.bus_addr, 32'd0);
    check("reset be", 32'(bus_if.bus_be), 32'd0);
    check("reset wdata", bus_if.bus_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Illegal size: done+err in the cycle after start, no bus activity, rdata kept.
    @(negedge CLK);
    drive_start(1'b0, 2'b11, 1'b0, 32'h700, 32'h0);
    @(negedge CLK);
    idle_inputs();
    check("illegal done", 32'(done), 32'd1);
    check("illegal err", 32'(err), 32'd1);
    check("illegal req", 32'(bus_if.bus_req), 32'd0);
    check("illegal stall", 32'(stall), 32'd0);
    check("illegal rdata kept", rdata, 32'h11223344);
    @(negedge CLK);
    check("illegal done one cycle", 32'(done), 32'd0);
    check("illegal req after", 32'(bus_if.bus_req), 32'd0);

    // start while busy and in FIN is ignored; ack outside a beat is ignored.
    @(negedge CLK);
    drive_start(1'b0, 2'b00, 1'b0, 32'h600, 32'h0);
    @(negedge CLK);
    idle_inputs();
    check("busy req", 32'(bus_if.bus_req), 32'd1);
    drive_start(1'b1, 2'b10, 1'b0, 32'h7F3, 32'h55);
    @(negedge CLK);
    idle_inputs();
    check("busy addr held", bus_if.bus_addr, 32'h600);
    check("busy we held", 32'(bus_if.bus_we), 32'd0);
    check("busy be held", 32'(bus_if.bus_be), 32'hF);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h0BADF00D;
    @(negedge CLK);
    bus_if.bus_rdata = IDLE_RDATA;
    check("busy done", 32'(done), 32'd1);
    check("busy rdata", rdata, 32'h0BADF00D);
    drive_start(1'b0, 2'b00, 1'b0, 32'h800, 32'h0);
    @(negedge CLK);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fin start ignored req %0d", k), 32'(bus_if.bus_req), 32'd0);
      check($sformatf("fin start ignored stall %0d", k), 32'(stall), 32'd0);
      check($sformatf("stray ack done %0d", k), 32'(done), 32'd0);
      @(negedge CLK);
    end
    bus_if.bus_ack = 1'b0;

    // Reset during BEAT0 with the request outstanding.
    drive_start(1'b1, 2'b00, 1'b0, 32'h900, 32'h12345678);
    @(negedge CLK);
    idle_inputs();
    check("rst-mid req before", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    @(negedge CLK);
    check("rst-mid stall", 32'(stall), 32'd0);
    check("rst-mid done", 32'(done), 32'd0);
    check("rst-mid rdata", rdata, 32'd0);
    check("rst-mid req", 32'(bus_if.bus_req), 32'd0);
    check("rst-mid we", 32'(bus_if.bus_we), 32'd0);
    check("rst-mid addr", bus_if.bus_addr, 32'd0);
    check("rst-mid be", 32'(bus_if.bus_be), 32'd0);
    check("rst-mid wdata", bus_if.bus_wdata, 32'd0);
    rst = 1'b0;
    @(negedge CLK);
    check("rst-mid stays idle", 32'(bus_if.bus_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
